// File: rtl/commit_store_queue.sv
// rtl/commit_store_queue.sv - commit-stage store queue with drain handshake and store-to-load forwarding
//
// Holds stores in program order from rename allocation through write-back,
// ROB commit and drain to data memory.
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   alloc_v_i / alloc_ready_o      allocate one store at the tail
//   alloc_num_o                    tail pointer (entry number with wrap bit)
//   wb_v_i, wb_num_i, wb_addr_i, wb_data_i   execute write-back of one entry
//   commit_cnt_i                   stores retired by the ROB this cycle
//   flush_i                        discard all uncommitted entries
//   mem_w_v_o / mem_w_ready_i      drain handshake, head store addr/data
//   clear_v_o / clear_num_o        entry freed this cycle and its index
//   ld_addr_i, ld_sb_num_i         load address and tail snapshot
//   ld_hit_o, ld_data_o, ld_stall_o forwarding result
//   wb_vector_o, commit_pt_o, count_o        status
module commit_store_queue #(
    parameter int WORD_SIZE_P    = 16,
    parameter int SB_ENTRY_P     = 8,
    parameter int COMMIT_WIDTH_P = 2,
    localparam int PW = $clog2(SB_ENTRY_P) + 1,
    localparam int IW = PW - 1,
    localparam int CW = $clog2(COMMIT_WIDTH_P + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   alloc_v_i,
    output logic                   alloc_ready_o,
    output logic [PW-1:0]          alloc_num_o,
    input  logic                   wb_v_i,
    input  logic [IW-1:0]          wb_num_i,
    input  logic [WORD_SIZE_P-1:0] wb_addr_i,
    input  logic [WORD_SIZE_P-1:0] wb_data_i,
    input  logic [CW-1:0]          commit_cnt_i,
    input  logic                   flush_i,
    output logic                   mem_w_v_o,
    output logic [WORD_SIZE_P-1:0] mem_w_addr_o,
    output logic [WORD_SIZE_P-1:0] mem_w_data_o,
    input  logic                   mem_w_ready_i,
    output logic                   clear_v_o,
    output logic [IW-1:0]          clear_num_o,
    input  logic [WORD_SIZE_P-1:0] ld_addr_i,
    input  logic [PW-1:0]          ld_sb_num_i,
    output logic                   ld_hit_o,
    output logic [WORD_SIZE_P-1:0] ld_data_o,
    output logic                   ld_stall_o,
    output logic [SB_ENTRY_P-1:0]  wb_vector_o,
    output logic [PW-1:0]          commit_pt_o,
    output logic [PW-1:0]          count_o
);

    logic [PW-1:0]          head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [SB_ENTRY_P-1:0]  wb_q, wb_d;
    logic [WORD_SIZE_P-1:0] addr_q [SB_ENTRY_P];
    logic [WORD_SIZE_P-1:0] data_q [SB_ENTRY_P];

    logic [PW-1:0]          occupied, uncommitted, commit_ext, commit_amt, fwd_len;
    logic [IW-1:0]          head_idx, tail_idx, cmt_idx, wb_off;
    logic                   full, alloc_fire, wb_fire, drain_fire;
    logic                   fwd_hit, fwd_stall;
    logic [WORD_SIZE_P-1:0] fwd_data;

    assign head_idx    = head_q[IW-1:0];
    assign tail_idx    = tail_q[IW-1:0];
    assign cmt_idx     = cmt_q[IW-1:0];
    assign occupied    = tail_q - head_q;
    assign uncommitted = tail_q - cmt_q;
    assign full        = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);

    assign alloc_ready_o = reset_i || (!full && !flush_i);
    assign alloc_fire    = alloc_v_i && !full && !flush_i;

    // A write-back is accepted only for entries in [cmt, tail): the index's
    // distance from cmt must be below the number of uncommitted entries.
    assign wb_off  = wb_num_i - cmt_idx;
    assign wb_fire = wb_v_i && !flush_i && ({1'b0, wb_off} < uncommitted);

    // Commit count saturates at the number of uncommitted entries.
    assign commit_ext = PW'(commit_cnt_i);
    assign commit_amt = (commit_ext < uncommitted) ? commit_ext : uncommitted;

    assign mem_w_v_o    = (head_q != cmt_q);
    assign mem_w_addr_o = addr_q[head_idx];
    assign mem_w_data_o = data_q[head_idx];
    assign drain_fire   = mem_w_v_o && mem_w_ready_i;
    assign clear_v_o    = drain_fire;
    assign clear_num_o  = head_idx;

    assign alloc_num_o = tail_q;
    assign wb_vector_o = wb_q;
    assign commit_pt_o = cmt_q;
    assign count_o     = occupied;

    always_comb begin
        head_d = drain_fire ? head_q + PW'(1) : head_q;
        cmt_d  = cmt_q + commit_amt;
        // Flush snaps the tail onto the post-commit cmt pointer.
        if (flush_i) begin
            tail_d = cmt_d;
        end else if (alloc_fire) begin
            tail_d = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end
        wb_d = wb_q;
        if (alloc_fire) begin
            wb_d[tail_idx] = 1'b0;
        end
        if (wb_fire) begin
            wb_d[wb_num_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            wb_q   <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            wb_q   <= wb_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wb_fire) begin
            addr_q[wb_num_i] <= wb_addr_i;
            data_q[wb_num_i] <= wb_data_i;
        end
    end

    // Walk [head, ld_sb_num) oldest to youngest so the last match wins.
    assign fwd_len = ld_sb_num_i - head_q;

    always_comb begin
        fwd_hit   = 1'b0;
        fwd_stall = 1'b0;
        fwd_data  = '0;
        for (int k = 0; k < SB_ENTRY_P; k++) begin
            if (PW'(k) < fwd_len) begin
                if (!wb_q[head_idx + IW'(k)]) begin
                    fwd_stall = 1'b1;
                end else if (addr_q[head_idx + IW'(k)] == ld_addr_i) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[head_idx + IW'(k)];
                end
            end
        end
    end

    assign ld_stall_o = fwd_stall && !reset_i;
    assign ld_hit_o   = fwd_hit && !fwd_stall && !reset_i;
    assign ld_data_o  = fwd_data;

endmodule

// File: tb/tb_commit_store_queue.sv
// tb/tb_commit_store_queue.sv - self-checking bench for commit_store_queue
module tb_commit_store_queue;
    localparam int W = 16, N = 8, PW = 4, CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, alloc_v, wb_v, flush, mem_ready;
    logic [PW-2:0] wb_num;
    logic [W-1:0] wb_addr, wb_data, ld_addr;
    logic [CW-1:0] commit_cnt;
    logic [PW-1:0] ld_sb_num;
    logic alloc_ready_o, mem_w_v_o, clear_v_o, ld_hit_o, ld_stall_o;
    logic [PW-1:0] alloc_num_o, commit_pt_o, count_o;
    logic [W-1:0] mem_w_addr_o, mem_w_data_o, ld_data_o;
    logic [PW-2:0] clear_num_o;
    logic [N-1:0] wb_vector_o;

    int n_tests = 0, n_fail = 0;

    // Reference model: absolute sequence numbers, entry storage by seq % N.
    int m_head, m_cmt, m_tail;
    logic [W-1:0] m_addr [N];
    logic [W-1:0] m_data [N];
    bit m_wb [N];

    commit_store_queue dut (
        .clk_i(clk), .reset_i(reset),
        .alloc_v_i(alloc_v), .alloc_ready_o(alloc_ready_o), .alloc_num_o(alloc_num_o),
        .wb_v_i(wb_v), .wb_num_i(wb_num), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .commit_cnt_i(commit_cnt), .flush_i(flush),
        .mem_w_v_o(mem_w_v_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
        .mem_w_ready_i(mem_ready), .clear_v_o(clear_v_o), .clear_num_o(clear_num_o),
        .ld_addr_i(ld_addr), .ld_sb_num_i(ld_sb_num), .ld_hit_o(ld_hit_o),
        .ld_data_o(ld_data_o), .ld_stall_o(ld_stall_o),
        .wb_vector_o(wb_vector_o), .commit_pt_o(commit_pt_o), .count_o(count_o)
    );

    task automatic idle();
        alloc_v = 0; wb_v = 0; wb_num = 0; wb_addr = 0; wb_data = 0;
        commit_cnt = 0; flush = 0; mem_ready = 0; ld_addr = 0; ld_sb_num = 0;
    endtask

    task automatic model_reset();
        m_head = 0; m_cmt = 0; m_tail = 0;
        for (int i = 0; i < N; i++) begin m_wb[i] = 0; m_addr[i] = 0; m_data[i] = 0; end
    endtask

    task automatic model_step();
        int unc, c;
        bit afire, dfire;
        unc = m_tail - m_cmt;
        c = (int'(commit_cnt) > unc) ? unc : int'(commit_cnt);
        afire = alloc_v && (m_tail - m_head < N) && !flush;
        dfire = mem_ready && (m_head < m_cmt);
        if (wb_v && !flush)
            for (int s = m_cmt; s < m_tail; s++)
                if (s % N == int'(wb_num)) begin
                    m_wb[s % N] = 1; m_addr[s % N] = wb_addr; m_data[s % N] = wb_data;
                end
        if (afire) begin m_wb[m_tail % N] = 0; m_tail++; end
        if (dfire) m_head++;
        m_cmt += c;
        if (flush) m_tail = m_cmt;
    endtask

    task automatic model_fwd(output bit hit, output bit stall, output logic [W-1:0] data);
        int len;
        hit = 0; stall = 0; data = 0;
        len = (int'(ld_sb_num) - (m_head % (2 * N)) + 2 * N) % (2 * N);
        for (int s = m_head; s < m_head + len; s++) begin
            if (!m_wb[s % N]) stall = 1;
            else if (m_addr[s % N] == ld_addr) begin hit = 1; data = m_data[s % N]; end
        end
        if (stall) hit = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); reset = 1; model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin alloc_v = 1; tick(); end
        alloc_v = 0;
    endtask

    task automatic wb_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] d);
        wb_v = 1; wb_num = 3'(idx); wb_addr = a; wb_data = d; tick(); wb_v = 0;
    endtask

    task automatic commit_one(input int c);
        commit_cnt = 2'(c); tick(); commit_cnt = 0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_alloc_ready got %0b exp 1", alloc_ready_o); end
        n_tests++; if (alloc_num_o !== 4'd0) begin n_fail++; $display("FAIL rst_alloc_num got %0d exp 0", alloc_num_o); end
        n_tests++; if (mem_w_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_v got %0b exp 0", mem_w_v_o); end
        n_tests++; if (clear_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_clear_v got %0b exp 0", clear_v_o); end
        n_tests++; if (ld_hit_o !== 1'b0 || ld_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_ld got hit %0b stall %0b exp 0 0", ld_hit_o, ld_stall_o); end
        n_tests++; if (count_o !== 4'd0 || commit_pt_o !== 4'd0) begin n_fail++; $display("FAIL rst_ptrs got count %0d cmt %0d exp 0 0", count_o, commit_pt_o); end
        n_tests++; if (wb_vector_o !== 8'h00) begin n_fail++; $display("FAIL rst_wb_vec got %h exp 00", wb_vector_o); end
        model_reset();
        @(negedge clk);
        reset = 0; ld_sb_num = 0;
    endtask

    task automatic test_fill_wrap();
        int pulses;
        do_reset();
        alloc_n(8);
        #1;
        n_tests++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %0b exp 0", alloc_ready_o); end
        n_tests++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d exp 8", count_o); end
        alloc_n(1);
        #1;
        n_tests++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL fill_ignored_count got %0d exp 8", count_o); end
        for (int i = 0; i < 8; i++) wb_one(i, 16'h0100 + 16'(i), 16'(i * 7 + 3));
        pulses = 0;
        mem_ready = 1; commit_cnt = 2;
        for (int cyc = 0; cyc < 20 && pulses < 8; cyc++) begin
            #1;
            if (clear_v_o) begin
                n_tests++; if (clear_num_o !== 3'(pulses)) begin n_fail++; $display("FAIL fill_clear_num got %0d exp %0d", clear_num_o, pulses); end
                n_tests++; if (mem_w_addr_o !== 16'h0100 + 16'(pulses)) begin n_fail++; $display("FAIL fill_mem_addr got %h exp %h", mem_w_addr_o, 16'h0100 + 16'(pulses)); end
                pulses++;
            end
            tick();
        end
        idle();
        #1;
        n_tests++; if (pulses != 8) begin n_fail++; $display("FAIL fill_pulses got %0d exp 8", pulses); end
        n_tests++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL fill_drained_count got %0d exp 0", count_o); end
        for (int i = 0; i < 3; i++) begin
            alloc_v = 1;
            #1;
            n_tests++; if (alloc_num_o !== 4'(8 + i) || alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL wrap_alloc_num got %0d rdy %0b exp %0d 1", alloc_num_o, alloc_ready_o, 8 + i); end
            tick();
        end
        alloc_v = 0;
    endtask

    task automatic test_back_pressure();
        do_reset();
        alloc_n(1);
        wb_one(0, 16'h0010, 16'hBEEF);
        commit_one(1);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++; if (mem_w_v_o !== 1'b1 || mem_w_addr_o !== 16'h0010 || mem_w_data_o !== 16'hBEEF || clear_v_o !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold got v %0b addr %h data %h clr %0b exp 1 0010 beef 0", mem_w_v_o, mem_w_addr_o, mem_w_data_o, clear_v_o); end
            tick();
        end
        mem_ready = 1;
        #1;
        n_tests++; if (clear_v_o !== 1'b1 || clear_num_o !== 3'd0) begin n_fail++; $display("FAIL bp_release got clr %0b num %0d exp 1 0", clear_v_o, clear_num_o); end
        tick();
        mem_ready = 0;
        #1;
        n_tests++; if (clear_v_o !== 1'b0 || mem_w_v_o !== 1'b0) begin n_fail++; $display("FAIL bp_single got clr %0b v %0b exp 0 0", clear_v_o, mem_w_v_o); end
    endtask

    task automatic test_flush();
        int writes;
        do_reset();
        alloc_n(6);
        for (int i = 0; i < 6; i++) if (i != 4) wb_one(i, 16'h0200 + 16'(i), 16'(i));
        commit_one(2);
        flush = 1; alloc_v = 1; wb_v = 1; wb_num = 3'd4; wb_addr = 16'h0999; wb_data = 16'h1234;
        #1;
        n_tests++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %0b exp 0", alloc_ready_o); end
        tick();
        idle();
        #1;
        n_tests++; if (commit_pt_o !== 4'd2 || count_o !== 4'd2) begin n_fail++; $display("FAIL flush_ptrs got cmt %0d count %0d exp 2 2", commit_pt_o, count_o); end
        n_tests++; if (alloc_num_o !== 4'd2) begin n_fail++; $display("FAIL flush_tail got %0d exp 2", alloc_num_o); end
        writes = 0;
        mem_ready = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (clear_v_o) writes++;
            tick();
        end
        mem_ready = 0;
        n_tests++; if (writes != 2) begin n_fail++; $display("FAIL flush_writes got %0d exp 2", writes); end
    endtask

    task automatic test_forward();
        logic [W-1:0] la [5]   = '{16'h40, 16'h40, 16'h40, 16'h50, 16'h60};
        logic [3:0]   sb [5]   = '{4'd3, 4'd2, 4'd0, 4'd3, 4'd3};
        bit           eh [5]   = '{1, 1, 0, 1, 0};
        logic [W-1:0] ed [5]   = '{16'h2222, 16'h1111, 16'h0, 16'h3333, 16'h0};
        do_reset();
        alloc_n(3);
        wb_one(0, 16'h0040, 16'h1111);
        wb_one(1, 16'h0050, 16'h3333);
        wb_one(2, 16'h0040, 16'h2222);
        for (int i = 0; i < 5; i++) begin
            ld_addr = la[i]; ld_sb_num = sb[i];
            #1;
            n_tests++; if (ld_hit_o !== eh[i] || ld_stall_o !== 1'b0) begin n_fail++; $display("FAIL fwd_hit[%0d] got hit %0b stall %0b exp %0b 0", i, ld_hit_o, ld_stall_o, eh[i]); end
            if (eh[i]) begin
                n_tests++; if (ld_data_o !== ed[i]) begin n_fail++; $display("FAIL fwd_data[%0d] got %h exp %h", i, ld_data_o, ed[i]); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        alloc_n(2);
        wb_one(0, 16'h0030, 16'hAAAA);
        ld_addr = 16'h0030; ld_sb_num = 4'd2;
        #1;
        n_tests++; if (ld_stall_o !== 1'b1 || ld_hit_o !== 1'b0) begin n_fail++; $display("FAIL stall_on got stall %0b hit %0b exp 1 0", ld_stall_o, ld_hit_o); end
        ld_sb_num = 4'd1;
        #1;
        n_tests++; if (ld_stall_o !== 1'b0 || ld_hit_o !== 1'b1 || ld_data_o !== 16'hAAAA) begin n_fail++; $display("FAIL stall_older got stall %0b hit %0b data %h exp 0 1 aaaa", ld_stall_o, ld_hit_o, ld_data_o); end
        ld_sb_num = 4'd2;
        wb_v = 1; wb_num = 3'd1; wb_addr = 16'h0031; wb_data = 16'h5555;
        #1;
        n_tests++; if (ld_stall_o !== 1'b1) begin n_fail++; $display("FAIL stall_same_cycle got %0b exp 1", ld_stall_o); end
        tick();
        wb_v = 0;
        #1;
        n_tests++; if (ld_stall_o !== 1'b0 || ld_hit_o !== 1'b1 || ld_data_o !== 16'hAAAA) begin n_fail++; $display("FAIL stall_off got stall %0b hit %0b data %h exp 0 1 aaaa", ld_stall_o, ld_hit_o, ld_data_o); end
    endtask

    task automatic test_commit_sat_reset();
        do_reset();
        alloc_n(1);
        wb_one(0, 16'h0022, 16'h3344);
        commit_cnt = 2;
        tick();
        commit_cnt = 0;
        #1;
        n_tests++; if (commit_pt_o !== 4'd1 || mem_w_v_o !== 1'b1) begin n_fail++; $display("FAIL sat_cmt got cmt %0d v %0b exp 1 1", commit_pt_o, mem_w_v_o); end
        n_tests++; if (mem_w_data_o !== 16'h3344) begin n_fail++; $display("FAIL sat_data got %h exp 3344", mem_w_data_o); end
        mem_ready = 1;
        reset = 1;
        #1;
        n_tests++; if (mem_w_v_o !== 1'b0 || count_o !== 4'd0 || clear_v_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset got v %0b count %0d clr %0b exp 0 0 0", mem_w_v_o, count_o, clear_v_o); end
        n_tests++; if (commit_pt_o !== 4'd0 || alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ptr got cmt %0d rdy %0b exp 0 1", commit_pt_o, alloc_ready_o); end
        idle(); model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_random();
        int k, c;
        bit eh, es, eclr;
        logic [W-1:0] ed;
        logic [N-1:0] evec, emask;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            alloc_v = 1'($urandom_range(0, 1));
            wb_v = 1'($urandom_range(0, 1));
            if (m_tail > m_cmt && $urandom_range(0, 4) != 0)
                wb_num = 3'((m_cmt + int'($urandom_range(0, m_tail - m_cmt - 1))) % N);
            else
                wb_num = 3'($urandom_range(0, 7));
            wb_addr = 16'h0040 + 16'($urandom_range(0, 3));
            wb_data = 16'($urandom);
            k = 0;
            while (m_cmt + k < m_tail && m_wb[(m_cmt + k) % N]) k++;
            c = int'($urandom_range(0, 3));
            if (c > k && k < m_tail - m_cmt) c = k;
            commit_cnt = 2'(c);
            flush = ($urandom_range(0, 15) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            ld_addr = 16'h0040 + 16'($urandom_range(0, 3));
            ld_sb_num = 4'((m_head + int'($urandom_range(0, m_tail - m_head))) % (2 * N));
            #1;
            model_fwd(eh, es, ed);
            eclr = mem_ready && (m_head < m_cmt);
            evec = '0; emask = '0;
            for (int s = m_head; s < m_tail; s++) begin emask[s % N] = 1; evec[s % N] = m_wb[s % N]; end
            n_tests++; if (alloc_ready_o !== ((m_tail - m_head < N) && !flush)) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %0b", cyc, alloc_ready_o); end
            n_tests++; if (alloc_num_o !== 4'(m_tail % 16) || commit_pt_o !== 4'(m_cmt % 16) || count_o !== 4'(m_tail - m_head)) begin
                n_fail++; $display("FAIL rnd_ptrs cyc %0d got tail %0d cmt %0d cnt %0d exp %0d %0d %0d", cyc, alloc_num_o, commit_pt_o, count_o, m_tail % 16, m_cmt % 16, m_tail - m_head); end
            n_tests++; if (mem_w_v_o !== (m_head < m_cmt) || clear_v_o !== eclr) begin n_fail++; $display("FAIL rnd_mem_v cyc %0d got v %0b clr %0b exp %0b %0b", cyc, mem_w_v_o, clear_v_o, m_head < m_cmt, eclr); end
            if (m_head < m_cmt) begin
                n_tests++; if (mem_w_addr_o !== m_addr[m_head % N] || mem_w_data_o !== m_data[m_head % N] || clear_num_o !== 3'(m_head % N)) begin
                    n_fail++; $display("FAIL rnd_mem_data cyc %0d got %h %h %0d exp %h %h %0d", cyc, mem_w_addr_o, mem_w_data_o, clear_num_o, m_addr[m_head % N], m_data[m_head % N], m_head % N); end
            end
            n_tests++; if (ld_hit_o !== eh || ld_stall_o !== es) begin n_fail++; $display("FAIL rnd_fwd cyc %0d got hit %0b stall %0b exp %0b %0b", cyc, ld_hit_o, ld_stall_o, eh, es); end
            if (eh) begin
                n_tests++; if (ld_data_o !== ed) begin n_fail++; $display("FAIL rnd_fwd_data cyc %0d got %h exp %h", cyc, ld_data_o, ed); end
            end
            n_tests++; if ((wb_vector_o & emask) !== (evec & emask)) begin n_fail++; $display("FAIL rnd_wb_vec cyc %0d got %h exp %h mask %h", cyc, wb_vector_o, evec, emask); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        ld_sb_num = 4'd5;
        test_reset();
        test_fill_wrap();
        test_back_pressure();
        test_flush();
        test_forward();
        test_stall();
        test_commit_sat_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
